// File: rtl/tone_scheduler_pkg.sv
// rtl/tone_scheduler_pkg.sv - pitch codes, FSM states and pitch-to-divider map for the note sequencer
package tone_pkg;

    localparam logic [3:0] PITCH_A     = 4'd0;
    localparam logic [3:0] PITCH_DHIGH = 4'd1;
    localparam logic [3:0] PITCH_C     = 4'd2;
    localparam logic [3:0] PITCH_B     = 4'd3;
    localparam logic [3:0] PITCH_G     = 4'd4;
    localparam logic [3:0] PITCH_FIS   = 4'd5;
    localparam logic [3:0] PITCH_E     = 4'd6;
    localparam logic [3:0] PITCH_D     = 4'd7;
    localparam logic [3:0] PITCH_REST  = 4'd15;

    localparam logic [4:0] MAXVAL_SILENT = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } tone_state_e;

    // Codes 8-15 all decode as rests, so only the top bit marks silence.
    function automatic logic pitch_is_rest(input logic [3:0] pitch);
        return pitch[3];
    endfunction

    function automatic logic [4:0] pitch_to_maxval(input logic [3:0] pitch);
        logic [4:0] mv;
        case (pitch)
            PITCH_A:     mv = 5'd18;
            PITCH_DHIGH: mv = 5'd13;
            PITCH_C:     mv = 5'd15;
            PITCH_B:     mv = 5'd16;
            PITCH_G:     mv = 5'd20;
            PITCH_FIS:   mv = 5'd21;
            PITCH_E:     mv = 5'd24;
            PITCH_D:     mv = 5'd27;
            default:     mv = MAXVAL_SILENT;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/tone_scheduler_if.sv
// rtl/tone_scheduler_if.sv - score write port shared by the loader and the sequencer
interface tone_scheduler_if #(
    parameter int DEPTH = 32,
    parameter int DUR_W = 13
);
    logic                     wr_en;
    logic [$clog2(DEPTH)-1:0] wr_addr;
    logic [3:0]               wr_pitch;
    logic [DUR_W-1:0]         wr_dur;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_pitch,
        output wr_dur
    );

    modport slave (
        input wr_en,
        input wr_addr,
        input wr_pitch,
        input wr_dur
    );
endinterface

// File: rtl/tone_scheduler_score_ram.sv
// rtl/tone_scheduler_score_ram.sv - simple dual-port score RAM, synchronous read, old data on collision
module score_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Both ports update on the same edge, so a colliding read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/tone_scheduler.sv
// rtl/tone_scheduler.sv - score-driven note sequencer feeding the sine clkgen divider and DAC gate
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int DUR_W = 13,
    parameter int GAP   = 80
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_tick,
    tone_scheduler_if.slave          wr,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    input  logic [$clog2(DEPTH):0]   len,
    output logic [4:0]               sine_maxval,
    output logic                     tone_en,
    output logic                     tone_restart,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] note_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      LEN_MAX = (AW + 1)'(DEPTH);
    localparam logic [DUR_W-1:0] GAP_D   = DUR_W'(GAP);

    tone_state_e      state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW:0]      len_q, len_d;
    logic             loop_q, loop_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic [4:0]       maxval_q, maxval_d;
    logic             tone_en_q, tone_en_d;
    logic             restart_q, restart_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [3+DUR_W:0] rd_data;
    logic [3:0]       rd_pitch;
    logic [DUR_W-1:0] rd_dur;
    logic             has_gap;
    logic [DUR_W-1:0] gap_start;
    logic [DUR_W-1:0] cnt_inc;
    logic             last_entry;
    logic             note_end;

    // The read address follows idx_d so the word lands exactly as FETCH begins.
    score_ram #(
        .DEPTH (DEPTH),
        .WIDTH (4 + DUR_W)
    ) u_score_ram (
        .clk       (clk),
        .wr_en_i   (wr.wr_en),
        .wr_addr_i (wr.wr_addr),
        .wr_data_i ({wr.wr_pitch, wr.wr_dur}),
        .rd_en_i   (state_d == ST_FETCH),
        .rd_addr_i (idx_d),
        .rd_data_o (rd_data)
    );

    assign rd_pitch   = rd_data[3+DUR_W:DUR_W];
    assign rd_dur     = rd_data[DUR_W-1:0];
    assign has_gap    = (dur_q > GAP_D);
    assign gap_start  = dur_q - GAP_D;
    assign cnt_inc    = cnt_q + DUR_W'(1);
    assign last_entry = ({1'b0, idx_q} == (len_q - (AW + 1)'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            dur_q     <= '0;
            cnt_q     <= '0;
            maxval_q  <= MAXVAL_SILENT;
            tone_en_q <= 1'b0;
            restart_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            loop_q    <= loop_d;
            dur_q     <= dur_d;
            cnt_q     <= cnt_d;
            maxval_q  <= maxval_d;
            tone_en_q <= tone_en_d;
            restart_q <= restart_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        loop_d    = loop_q;
        dur_d     = dur_q;
        cnt_d     = cnt_q;
        maxval_d  = maxval_q;
        tone_en_d = tone_en_q;
        restart_d = 1'b0;
        done_d    = 1'b0;
        note_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    len_d   = (len > LEN_MAX) ? LEN_MAX : len;
                    loop_d  = loop;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d   = ST_PLAY;
                dur_d     = (rd_dur == '0) ? DUR_W'(1) : rd_dur;
                maxval_d  = pitch_to_maxval(rd_pitch);
                tone_en_d = !pitch_is_rest(rd_pitch);
                restart_d = 1'b1;
                cnt_d     = '0;
            end
            ST_PLAY: begin
                if (sample_tick) begin
                    cnt_d = cnt_inc;
                    if (has_gap && (cnt_inc == gap_start)) begin
                        state_d   = ST_GAP;
                        tone_en_d = 1'b0;
                    end else if (!has_gap && (cnt_inc == dur_q)) begin
                        note_end = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (sample_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == dur_q) begin
                        note_end = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (note_end) begin
            tone_en_d = 1'b0;
            if (!last_entry) begin
                idx_d   = idx_q + AW'(1);
                state_d = ST_FETCH;
            end else if (loop_q) begin
                idx_d   = '0;
                state_d = ST_FETCH;
            end else begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        end

        // Abort overrides everything decided above, including a start or a final tick.
        if (stop) begin
            state_d   = ST_IDLE;
            tone_en_d = 1'b0;
            restart_d = 1'b0;
            done_d    = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign sine_maxval  = maxval_q;
    assign tone_en      = tone_en_q;
    assign tone_restart = restart_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign note_idx     = idx_q;

endmodule
